// File: rtl/ddc_gain_stage_mc_pkg.sv
// Shared definitions for the multi-channel DDC gain stage: settings offsets,
// control-register bit positions and a constant-evaluable clog2.
package ddc_gain_stage_mc_pkg;

    // Scale registers start at BASE+SR_SCALE0; control sits right after them.
    localparam int unsigned SR_SCALE0     = 0;
    localparam int unsigned CTRL_RND_BIT  = 0;
    localparam int unsigned CTRL_SWAP_BIT = 1;

    typedef struct packed {
        logic swap_iq;
        logic rnd_en;
    } ctrl_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Offset of the control register relative to BASE.
    function automatic int unsigned sr_ctrl(input int unsigned nchan);
        return SR_SCALE0 + nchan;
    endfunction

endpackage

// File: rtl/ddc_gain_stage_mc_result_fifo.sv
// Synchronous result FIFO. A push into a full FIFO is accepted only when a
// pop happens in the same cycle. No fall-through: a pushed entry shows up on
// the head the cycle after it is written. clr flushes like reset.
module ddc_result_fifo
    import ddc_gain_stage_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] entry,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage write; contents are irrelevant once count is flushed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= entry;
    end

endmodule

// File: rtl/ddc_gain_stage_mc.sv
// Multi-channel DDC back end: per-channel scale, round, clip, then queue the
// {chan, I, Q} result in a small FIFO. Fixed 4-cycle latency to FIFO push.
module ddc_gain_stage_mc
    import ddc_gain_stage_mc_pkg::*;
#(
    parameter int unsigned BASE        = 0,
    parameter int unsigned NCHAN       = 2,
    parameter int unsigned WIDTH       = 24,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter int unsigned SCALE_WIDTH = 18,
    parameter int unsigned FIFO_DEPTH  = 4,
    localparam int unsigned CW         = (NCHAN > 1) ? clog2(NCHAN) : 1
) (
    input  logic                   adc_clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   set_stb,
    input  logic [7:0]             set_addr,
    input  logic [31:0]            set_data,
    input  logic                   in_stb,
    input  logic [CW-1:0]          in_chan,
    input  logic [WIDTH-1:0]       in_i,
    input  logic [WIDTH-1:0]       in_q,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CW-1:0]          out_chan,
    output logic [2*OUT_WIDTH-1:0] out_sample,
    output logic [15:0]            sat_count,
    output logic [15:0]            drop_count,
    output logic                   overrun
);

    localparam int unsigned PW   = WIDTH + SCALE_WIDTH;
    localparam int unsigned DROP = WIDTH - OUT_WIDTH;
    localparam logic signed [WIDTH:0] HALF_POS = (WIDTH+1)'(2**(DROP-1));
    localparam logic signed [WIDTH:0] HALF_NEG = (WIDTH+1)'(2**(DROP-1) - 1);
    localparam logic [OUT_WIDTH-1:0] LIM_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] LIM_NEG = {1'b1, {(OUT_WIDTH-2){1'b0}}, 1'b1};

    typedef struct packed {
        logic                 sat;
        logic [OUT_WIDTH-1:0] val;
    } res_t;

    // Negative values get half-minus-one before the floor shift, which gives
    // round-half-away-from-zero using a single arithmetic shift.
    function automatic res_t rnd_clip(input logic signed [WIDTH-1:0] y,
                                      input logic ovf, input logic neg,
                                      input logic rnd);
        logic signed [WIDTH:0]     ext;
        logic signed [OUT_WIDTH:0] r;
        res_t                      res;
        ext = {y[WIDTH-1], y};
        if (rnd) ext = ext + (y[WIDTH-1] ? HALF_NEG : HALF_POS);
        r = (OUT_WIDTH+1)'(ext >>> DROP);
        res.sat = 1'b1;
        if (ovf)                            res.val = neg ? LIM_NEG : LIM_POS;
        else if (r > $signed({1'b0, LIM_POS})) res.val = LIM_POS;
        else if (r < $signed({1'b1, LIM_NEG})) res.val = LIM_NEG;
        else begin
            res.sat = 1'b0;
            res.val = r[OUT_WIDTH-1:0];
        end
        return res;
    endfunction

    logic signed [SCALE_WIDTH-1:0] scale [NCHAN];
    ctrl_t                         ctrl;

    logic                          s0_valid, s1_valid, s2_valid, s3_valid;
    logic [CW-1:0]                 s0_chan, s1_chan, s2_chan, s3_chan;
    ctrl_t                         s0_ctrl, s1_ctrl, s2_ctrl;
    logic signed [WIDTH-1:0]       s0_i, s0_q, s2_y_i, s2_y_q;
    logic signed [SCALE_WIDTH-1:0] s0_scale;
    logic signed [PW-1:0]          p_i, p_q;
    logic                          s2_ovf_i, s2_ovf_q, s2_neg_i, s2_neg_q;
    logic [2*OUT_WIDTH-1:0]        s3_sample;

    logic                          chan_ok;
    res_t                          res_i, res_q;
    logic                          any_sat;
    logic                          full, empty, pop, drop;
    logic                          unused_bits;

    assign chan_ok = (32'(in_chan) < NCHAN);
    assign unused_bits = ^{set_data[31:SCALE_WIDTH], p_i[PW-3-WIDTH:0], p_q[PW-3-WIDTH:0]};

    // Settings registers: per-channel scale and the control word.
    always_ff @(posedge adc_clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < NCHAN; c++) scale[c] <= '0;
            ctrl <= '0;
        end else if (set_stb) begin
            for (int unsigned c = 0; c < NCHAN; c++)
                if (set_addr == 8'(BASE + SR_SCALE0 + c)) scale[c] <= set_data[SCALE_WIDTH-1:0];
            if (set_addr == 8'(BASE + sr_ctrl(NCHAN))) begin
                ctrl.rnd_en  <= set_data[CTRL_RND_BIT];
                ctrl.swap_iq <= set_data[CTRL_SWAP_BIT];
            end
        end
    end

    // Pipeline valid bits; bad channels never enter the pipe.
    always_ff @(posedge adc_clk) begin
        if (rst || clr) begin
            s0_valid <= 1'b0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            s0_valid <= in_stb & chan_ok;
            s1_valid <= s0_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    // Pipeline data: S0 capture/lookup, S1 multiply, S2 range check, S3 result.
    always_ff @(posedge adc_clk) begin
        s0_chan   <= in_chan;
        s0_i      <= in_i;
        s0_q      <= in_q;
        s0_scale  <= chan_ok ? scale[in_chan] : '0;
        s0_ctrl   <= ctrl;
        s1_chan   <= s0_chan;
        s1_ctrl   <= s0_ctrl;
        p_i       <= PW'(s0_i) * PW'(s0_scale);
        p_q       <= PW'(s0_q) * PW'(s0_scale);
        s2_chan   <= s1_chan;
        s2_ctrl   <= s1_ctrl;
        s2_y_i    <= p_i[PW-3 -: WIDTH];
        s2_y_q    <= p_q[PW-3 -: WIDTH];
        s2_ovf_i  <= !((p_i[PW-1:PW-3] == '0) || (p_i[PW-1:PW-3] == '1));
        s2_ovf_q  <= !((p_q[PW-1:PW-3] == '0) || (p_q[PW-1:PW-3] == '1));
        s2_neg_i  <= p_i[PW-1];
        s2_neg_q  <= p_q[PW-1];
        s3_chan   <= s2_chan;
        s3_sample <= s2_ctrl.swap_iq ? {res_q.val, res_i.val} : {res_i.val, res_q.val};
    end

    // Rounding and clipping of the S2 values feeding S3.
    always_comb begin
        res_i   = rnd_clip(s2_y_i, s2_ovf_i, s2_neg_i, s2_ctrl.rnd_en);
        res_q   = rnd_clip(s2_y_q, s2_ovf_q, s2_neg_q, s2_ctrl.rnd_en);
        any_sat = res_i.sat | res_q.sat;
    end

    assign pop  = ~empty & out_ready;
    assign drop = s3_valid & full & ~pop;

    // Saturating event counters and the sticky overrun flag.
    always_ff @(posedge adc_clk) begin
        if (rst || clr) begin
            sat_count  <= '0;
            drop_count <= '0;
            overrun    <= 1'b0;
        end else begin
            if (s2_valid && any_sat && sat_count != '1) sat_count <= sat_count + 1'b1;
            if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
            if (drop) overrun <= 1'b1;
        end
    end

    ddc_result_fifo #(
        .WIDTH (CW + 2*OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (adc_clk),
        .rst   (rst),
        .clr   (clr),
        .push  (s3_valid),
        .pop   (pop),
        .entry ({s3_chan, s3_sample}),
        .head  ({out_chan, out_sample}),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = ~empty;

endmodule

// File: tb/tb_ddc_gain_stage_mc.sv
// Directed bench for ddc_gain_stage_mc with three channels (chan 3 is invalid).
module tb_ddc_gain_stage_mc;

    logic        adc_clk = 1'b0;
    logic        rst = 1'b1, clr = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic        in_stb = 1'b0;
    logic [1:0]  in_chan = '0;
    logic [23:0] in_i = '0, in_q = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [1:0]  out_chan;
    logic [31:0] out_sample;
    logic [15:0] sat_count, drop_count;
    logic        overrun;

    int total = 0;
    int bad   = 0;
    int exp_sat = 0;

    localparam logic [7:0] CTRL_ADDR = 8'd3;

    ddc_gain_stage_mc #(
        .NCHAN (3)
    ) dut (
        .adc_clk    (adc_clk),
        .rst        (rst),
        .clr        (clr),
        .set_stb    (set_stb),
        .set_addr   (set_addr),
        .set_data   (set_data),
        .in_stb     (in_stb),
        .in_chan    (in_chan),
        .in_i       (in_i),
        .in_q       (in_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_chan   (out_chan),
        .out_sample (out_sample),
        .sat_count  (sat_count),
        .drop_count (drop_count),
        .overrun    (overrun)
    );

    always #5 adc_clk = ~adc_clk;

    typedef struct {
        logic [1:0]  chan;
        logic [23:0] i, q;
        logic        rnd, swap;
        logic [15:0] ei, eq;
        int          sat;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        tick();
        set_stb = 1'b0;
    endtask

    task automatic send(input logic [1:0] ch, input logic [23:0] i, input logic [23:0] q);
        in_stb = 1'b1; in_chan = ch; in_i = i; in_q = q;
        tick();
        in_stb = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [1:0] ch, input logic [31:0] s);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_chan"}, 64'(out_chan), 64'(ch));
        check({tag, "_sample"}, 64'(out_sample), 64'(s));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            chan  in_i        in_q        rnd   swap  exp_i     exp_q     sat
        vecs[0]  = '{2'd0, 24'd4736,   24'hFFED80, 1'b1, 1'b0, 16'h0013, 16'hFFED, 0};
        vecs[1]  = '{2'd0, 24'd4736,   24'hFFED80, 1'b0, 1'b0, 16'h0012, 16'hFFED, 0};
        vecs[2]  = '{2'd1, 24'h7FFFFF, 24'h800000, 1'b1, 1'b0, 16'h7FFF, 16'h8001, 1};
        vecs[3]  = '{2'd2, 24'd25600,  24'd25600,  1'b1, 1'b0, 16'd50,   16'd50,   0};
        vecs[4]  = '{2'd0, 24'd4736,   24'hFFED80, 1'b1, 1'b1, 16'hFFED, 16'h0013, 0};
        vecs[5]  = '{2'd0, 24'h800000, 24'h7FFFFF, 1'b1, 1'b0, 16'h8001, 16'h7FFF, 1};
        vecs[6]  = '{2'd0, 24'h800000, 24'h7FFFFF, 1'b0, 1'b0, 16'h8001, 16'h7FFF, 1};
        vecs[7]  = '{2'd0, 24'd128,    24'hFFFF81, 1'b1, 1'b0, 16'd1,    16'd0,    0};
        vecs[8]  = '{2'd0, 24'd128,    24'hFFFFFF, 1'b0, 1'b0, 16'd0,    16'hFFFF, 0};
        vecs[9]  = '{2'd2, 24'h7FFFFF, 24'd0,      1'b1, 1'b0, 16'h4000, 16'd0,    0};
        vecs[10] = '{2'd1, 24'd1000,   24'hFFFC18, 1'b0, 1'b0, 16'd7,    16'hFFF8, 0};

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_chan", 64'(out_chan), 64'd0);
        check("rst_sample", 64'(out_sample), 64'd0);
        check("rst_sat", 64'(sat_count), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);

        set_reg(8'd0, 32'd65536);
        set_reg(8'd1, 32'd131071);
        set_reg(8'd2, 32'd32768);

        // Table: exact 4-cycle latency, value, then pop back to empty
        for (int v = 0; v < 11; v++) begin
            set_reg(CTRL_ADDR, {30'd0, vecs[v].swap, vecs[v].rnd});
            send(vecs[v].chan, vecs[v].i, vecs[v].q);
            for (int k = 1; k <= 3; k++) begin
                tick();
                check($sformatf("v%0d_early%0d", v, k), 64'(out_valid), 64'd0);
            end
            tick();
            exp_sat += vecs[v].sat;
            pop_expect($sformatf("v%0d", v), vecs[v].chan, {vecs[v].ei, vecs[v].eq});
            check($sformatf("v%0d_sat", v), 64'(sat_count), 64'(exp_sat));
            check($sformatf("v%0d_empty", v), 64'(out_valid), 64'd0);
        end

        // Interleaved channels every cycle
        set_reg(8'd1, 32'd32768);
        set_reg(CTRL_ADDR, 32'd1);
        for (int k = 0; k < 4; k++) send(2'(k % 2), 24'd25600, 24'd25600);
        repeat (4) tick();
        for (int k = 0; k < 4; k++)
            pop_expect($sformatf("ilv%0d", k), 2'(k % 2), (k % 2 == 0) ? {16'd100, 16'd100} : {16'd50, 16'd50});
        check("ilv_empty", 64'(out_valid), 64'd0);

        // Back-pressure: six pushes into four entries
        for (int k = 1; k <= 6; k++) send(2'd0, 24'(256 * k), 24'(-256 * k));
        repeat (5) tick();
        check("bp_drop", 64'(drop_count), 64'd2);
        check("bp_overrun", 64'(overrun), 64'd1);
        check("bp_sat", 64'(sat_count), 64'(exp_sat));
        for (int k = 1; k <= 4; k++)
            pop_expect($sformatf("bp%0d", k), 2'd0, {16'(k), 16'(-k)});
        check("bp_empty", 64'(out_valid), 64'd0);

        // Full FIFO with a pop in the same cycle as the push
        for (int k = 1; k <= 5; k++) send(2'd0, 24'(256 * k), 24'(-256 * k));
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("fp_drop", 64'(drop_count), 64'd2);
        for (int k = 2; k <= 5; k++)
            pop_expect($sformatf("fp%0d", k), 2'd0, {16'(k), 16'(-k)});
        check("fp_empty", 64'(out_valid), 64'd0);

        // clr two cycles after in_stb, with an entry already queued
        send(2'd0, 24'(256 * 7), 24'(-256 * 7));
        repeat (4) tick();
        check("clr_pre_valid", 64'(out_valid), 64'd1);
        send(2'd1, 24'h7FFFFF, 24'h800000);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_valid", 64'(out_valid), 64'd0);
        check("clr_drop", 64'(drop_count), 64'd0);
        check("clr_overrun", 64'(overrun), 64'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("clr_idle%0d", k), 64'(out_valid), 64'd0);
        end
        check("clr_sat", 64'(sat_count), 64'd0);

        // Invalid channel never reaches the FIFO or counters
        send(2'd3, 24'h7FFFFF, 24'h800000);
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("bad_idle%0d", k), 64'(out_valid), 64'd0);
        end
        check("bad_sat", 64'(sat_count), 64'd0);
        check("bad_drop", 64'(drop_count), 64'd0);

        // rst zeroes scales; a write only affects samples from the next cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_valid", 64'(out_valid), 64'd0);
        set_stb = 1'b1; set_addr = 8'd0; set_data = 32'd32768;
        in_stb = 1'b1; in_chan = 2'd0; in_i = 24'd25600; in_q = 24'd25600;
        tick();
        set_stb = 1'b0;
        send(2'd0, 24'd25600, 24'd25600);
        repeat (3) tick();
        pop_expect("rst2_old", 2'd0, 32'd0);
        pop_expect("rst2_new", 2'd0, {16'd50, 16'd50});
        check("rst2_empty", 64'(out_valid), 64'd0);
        check("rst2_sat", 64'(sat_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
